// File: rtl/oled_pkg.sv
// Shared constants and types for the 96x64 OLED framebuffer path.
package oled_pkg;

  localparam int SCR_W   = 96;
  localparam int SCR_H   = 64;
  localparam int PIX_CNT = 6144;
  localparam int IDX_W   = 13;
  localparam int X_W     = 7;
  localparam int Y_W     = 6;

  typedef logic [IDX_W-1:0] pixel_idx_t;
  typedef logic [15:0]      rgb565_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } rect_state_t;

  // y*96 as (y<<6)+(y<<5) so no multiplier is inferred
  function automatic pixel_idx_t row_base_of(input logic [Y_W-1:0] y);
    pixel_idx_t s64;
    pixel_idx_t s32;
    s64 = {1'b0, y, 6'b000000};
    s32 = {2'b00, y, 5'b00000};
    return s64 + s32;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row/row_base stepping for a raster-order rectangle walk.
module raster_counter
  import oled_pkg::*;
#(
  parameter int ROW_STEP = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             adv,
  input  logic [X_W-1:0]   w_in,
  input  logic [X_W-1:0]   h_in,
  input  pixel_idx_t       base_in,
  output logic [X_W-1:0]   col_d,
  output pixel_idx_t       row_base_d,
  output logic             last
);

  logic [X_W-1:0] col_q;
  logic [X_W-1:0] row_q;
  logic [X_W-1:0] row_d;
  logic [X_W-1:0] w_m1_q;
  logic [X_W-1:0] w_m1_d;
  logic [X_W-1:0] h_m1_q;
  logic [X_W-1:0] h_m1_d;
  pixel_idx_t     row_base_q;

  assign last = (col_q == w_m1_q) && (row_q == h_m1_q);

  // Next-position logic: load starts at the top-left, adv steps in raster order
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    w_m1_d     = w_m1_q;
    h_m1_d     = h_m1_q;
    if (load) begin
      col_d      = 7'd0;
      row_d      = 7'd0;
      row_base_d = base_in;
      w_m1_d     = w_in - 7'd1;
      h_m1_d     = h_in - 7'd1;
    end else if (adv) begin
      if (col_q == w_m1_q) begin
        col_d      = 7'd0;
        row_d      = row_q + 7'd1;
        row_base_d = row_base_q + IDX_W'(ROW_STEP);
      end else begin
        col_d      = col_q + 7'd1;
      end
    end else begin
      col_d      = col_q;
      row_d      = row_q;
    end
  end

  // Position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= 7'd0;
      row_q      <= 7'd0;
      row_base_q <= 13'd0;
      w_m1_q     <= 7'd0;
      h_m1_q     <= 7'd0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      w_m1_q     <= w_m1_d;
      h_m1_q     <= h_m1_d;
    end
  end

endmodule

// File: rtl/rect_pixel_writer.sv
// Rectangle-fill command to linear framebuffer write stream (index = y*96 + x).
// Optional clipping to the visible screen is enabled with `define RECT_CLIP_EN.
module rect_pixel_writer
  import oled_pkg::*;
#(
  parameter int SCR_W   = 96,
  parameter int SCR_H   = 64,
  parameter int COLOR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [6:0]         cmd_x0,
  input  logic [5:0]         cmd_y0,
  input  logic [6:0]         cmd_w,
  input  logic [6:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [12:0]        wr_index,
  output logic [COLOR_W-1:0] wr_color,
  output logic               busy,
  output logic               done
);

  rect_state_t        state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               wr_valid_q, wr_valid_d;
  pixel_idx_t         wr_index_q, wr_index_d;
  logic [COLOR_W-1:0] wr_color_q, wr_color_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [6:0]         x0_q, x0_d;

  logic               load_s;
  logic               adv_s;
  logic               last_s;
  logic [6:0]         col_nxt_s;
  pixel_idx_t         row_base_nxt_s;
  logic [6:0]         w_eff_s;
  logic [6:0]         h_eff_s;
  logic [6:0]         x0_src_s;
  pixel_idx_t         idx_nxt_s;

`ifdef RECT_CLIP_EN
  logic [7:0] x_end_s;
  logic [7:0] y_end_s;

  // Clamp the rectangle to the visible area; clipped pixels never become beats
  always_comb begin
    x_end_s = {1'b0, cmd_x0} + {1'b0, cmd_w};
    y_end_s = {2'b00, cmd_y0} + {1'b0, cmd_h};
    if ({1'b0, cmd_x0} >= 8'(SCR_W)) begin
      w_eff_s = 7'd0;
    end else if (x_end_s > 8'(SCR_W)) begin
      w_eff_s = 7'(8'(SCR_W) - {1'b0, cmd_x0});
    end else begin
      w_eff_s = cmd_w;
    end
    if ({2'b00, cmd_y0} >= 8'(SCR_H)) begin
      h_eff_s = 7'd0;
    end else if (y_end_s > 8'(SCR_H)) begin
      h_eff_s = 7'(8'(SCR_H) - {2'b00, cmd_y0});
    end else begin
      h_eff_s = cmd_h;
    end
  end
`else
  logic unused_scr_h_s;
  assign unused_scr_h_s = (SCR_H == 0);
  assign w_eff_s = cmd_w;
  assign h_eff_s = cmd_h;
`endif

  raster_counter #(
    .ROW_STEP (SCR_W)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .adv        (adv_s),
    .w_in       (w_eff_s),
    .h_in       (h_eff_s),
    .base_in    (row_base_of(cmd_y0)),
    .col_d      (col_nxt_s),
    .row_base_d (row_base_nxt_s),
    .last       (last_s)
  );

  assign x0_src_s  = load_s ? cmd_x0 : x0_q;
  // Upper carry is dropped: without clipping an off-screen x spills into the next row
  assign idx_nxt_s = row_base_nxt_s + pixel_idx_t'(x0_src_s) + pixel_idx_t'(col_nxt_s);

  // FSM next state and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    wr_valid_d  = wr_valid_q;
    wr_color_d  = wr_color_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    x0_d        = x0_q;
    load_s      = 1'b0;
    adv_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          load_s      = 1'b1;
          x0_d        = cmd_x0;
          wr_color_d  = cmd_color;
          cmd_ready_d = 1'b0;
          if ((w_eff_s == 7'd0) || (h_eff_s == 7'd0)) begin
            state_d    = FIN;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            wr_valid_d = 1'b0;
          end else begin
            state_d    = RUN;
            busy_d     = 1'b1;
            wr_valid_d = 1'b1;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      RUN: begin
        if (wr_ready) begin
          if (last_s) begin
            state_d    = FIN;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            wr_valid_d = 1'b0;
          end else begin
            adv_s      = 1'b1;
          end
        end else begin
          adv_s = 1'b0;
        end
      end
      FIN: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        wr_valid_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
    wr_index_d = (load_s || adv_s) ? idx_nxt_s : wr_index_q;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_index_q  <= 13'd0;
      wr_color_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      x0_q        <= 7'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wr_valid_q  <= wr_valid_d;
      wr_index_q  <= wr_index_d;
      wr_color_q  <= wr_color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      x0_q        <= x0_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_valid  = wr_valid_q;
  assign wr_index  = wr_index_q;
  assign wr_color  = wr_color_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rect_pixel_writer.sv
// Self-checking bench for rect_pixel_writer: directed corner cases plus random commands.
module tb_rect_pixel_writer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x0;
  logic [5:0]  cmd_y0;
  logic [6:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        wr_valid;
  logic        wr_ready;
  logic [12:0] wr_index;
  logic [15:0] wr_color;
  logic        busy;
  logic        done;

  int n_asserts = 0;
  int n_fail    = 0;
  int unsigned exp_q[$];

  rect_pixel_writer #(.SCR_W(96), .SCR_H(64), .COLOR_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_index  (wr_index),
    .wr_color  (wr_color),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: raster walk of the rectangle in screen coordinates
  task automatic build_expected(input int x0, input int y0, input int w, input int h);
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
`ifdef RECT_CLIP_EN
        if ((x0 + c) < 96 && (y0 + r) < 64)
          exp_q.push_back((y0 + r) * 96 + x0 + c);
`else
        exp_q.push_back(((y0 + r) * 96 + x0 + c) % 8192);
`endif
      end
    end
  endtask

  // mode 0: wr_ready always 1; 1: random; 2: pattern 1,0,0,1,1 repeating
  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input logic [15:0] col, input int mode, input int abort_after);
    int k;
    int cyc;
    int total;
    bit finished;
    logic [4:0] pat;
    pat = 5'b11001;
    build_expected(x0, y0, w, h);
    total = exp_q.size();
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_x0 = 7'(x0); cmd_y0 = 6'(y0); cmd_w = 7'(w); cmd_h = 7'(h);
    cmd_color = col; cmd_valid = 1'b1; wr_ready = 1'b0;
    @(negedge clk);
    k = 0; cyc = 1; finished = 0;
    while (!finished) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_x0 = 7'($urandom); cmd_y0 = 6'($urandom); cmd_w = 7'($urandom); cmd_h = 7'($urandom);
      if (k < total) begin
        check("wr_valid_run", {31'd0, wr_valid}, 32'd1);
        check("busy_run", {31'd0, busy}, 32'd1);
        check("cmd_ready_run", {31'd0, cmd_ready}, 32'd0);
        check("wr_index", {19'd0, wr_index}, exp_q[k]);
        check("wr_color", {16'd0, wr_color}, {16'd0, col});
        case (mode)
          0: wr_ready = 1'b1;
          1: wr_ready = 1'($urandom_range(0, 1));
          default: wr_ready = pat[(cyc - 1) % 5];
        endcase
        if (wr_valid && wr_ready) k++;
        if (abort_after > 0 && k >= abort_after) return;
      end else begin
        check("done_pulse", {31'd0, done}, 32'd1);
        check("wr_valid_fin", {31'd0, wr_valid}, 32'd0);
        check("busy_fin", {31'd0, busy}, 32'd0);
        check("beat_count", k, total);
        if (mode == 0) check("done_latency", cyc, total + 1);
        cmd_valid = 1'b0;
        wr_ready = 1'b0;
        @(negedge clk);
        check("done_clear", {31'd0, done}, 32'd0);
        check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        finished = 1;
      end
      if (!finished) begin
        if (cyc > total * 8 + 10) begin
          check("cycle_budget", cyc, total * 8 + 10);
          cmd_valid = 1'b0;
          finished = 1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; wr_ready = 1'b0;
    cmd_x0 = 7'd0; cmd_y0 = 6'd0; cmd_w = 7'd0; cmd_h = 7'd0; cmd_color = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_index", {19'd0, wr_index}, 32'd0);
    check("rst_wr_color", {16'd0, wr_color}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Basic fill: 0,1,96,97
    run_cmd(0, 0, 2, 2, 16'hF800, 0, 0);
    // Bottom-right corner: 6143
    run_cmd(95, 63, 1, 1, 16'h07E0, 0, 0);
    // Backpressure: 490,491,492
    run_cmd(10, 5, 3, 1, 16'h001F, 2, 0);
    // Zero size
    run_cmd(20, 10, 0, 5, 16'h1234, 0, 0);
    run_cmd(20, 10, 5, 0, 16'h4321, 0, 0);
    // Clipping case (wraps without clipping)
    run_cmd(94, 62, 4, 4, 16'hABCD, 0, 0);
    run_cmd(100, 3, 5, 2, 16'h5555, 0, 0);

    // Reset mid-command after 100 beats
    run_cmd(0, 0, 96, 64, 16'hFFFF, 0, 100);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("abort_wr_index", {19'd0, wr_index}, 32'd0);
    check("abort_wr_color", {16'd0, wr_color}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    cmd_valid = 1'b0; wr_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_abort_done", {31'd0, done}, 32'd0);
    check("post_abort_valid", {31'd0, wr_valid}, 32'd0);
    run_cmd(3, 2, 2, 1, 16'h0F0F, 0, 0);

    // Random commands with random backpressure
    for (int i = 0; i < 25; i++) begin
      run_cmd($urandom_range(0, 110), $urandom_range(0, 63), $urandom_range(0, 12),
              $urandom_range(0, 8), 16'($urandom), (i % 2 == 0) ? 1 : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
